// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - Wishbone B4 pipelined register bank with byte lanes and fixed ack latency
module wb_regfile #(
    parameter int               WB_ADDR_WIDTH = 30,
    parameter int               NREGS         = 16,
    parameter int               ACK_DELAY     = 1,
    parameter logic [NREGS-1:0] RO_MASK       = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic [31:0]              o_wb_data,
    output logic [32*NREGS-1:0]      o_regs,
    input  logic [32*NREGS-1:0]      i_ro_data,
    output logic [NREGS-1:0]         o_wr_pulse
);

    localparam int         IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
    // Wide enough to hold NREGS=256 even when the address bus is narrow.
    localparam int         CMP_W    = (WB_ADDR_WIDTH > 10) ? WB_ADDR_WIDTH : 10;
    localparam logic [2:0] CTR_INIT = (ACK_DELAY >= 2) ? 3'(ACK_DELAY - 2) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t             r_state;
    logic [2:0]         r_ctr;
    logic               r_stall;
    logic [31:0]        r_regs [NREGS];
    logic [31:0]        r_rdata;
    logic [NREGS-1:0]   r_wr_pulse;

    logic               w_accept;
    logic               w_in_range;
    logic               w_is_ro;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_ro_word;

    assign w_accept   = i_wb_cyc & i_wb_stb & ~r_stall;
    assign w_in_range = CMP_W'(i_wb_addr) < CMP_W'(NREGS);
    assign w_idx      = i_wb_addr[IDX_W-1:0];
    assign w_is_ro    = RO_MASK[w_idx];
    assign w_ro_word  = i_ro_data[{w_idx, 5'b0} +: 32];

    assign o_wb_stall = r_stall;
    // Ack is gated by cyc so an abandoned cycle never sees a stray ack.
    assign o_wb_ack   = (r_state == S_ACK) & i_wb_cyc;
    assign o_wb_data  = r_rdata;
    assign o_wr_pulse = r_wr_pulse;

    // Handshake FSM: accept in IDLE or ACK, hold off with stall while counting down the latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ctr   <= 3'd0;
            r_stall <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACK: begin
                    if (w_accept) begin
                        if (ACK_DELAY == 1) begin
                            r_state <= S_ACK;
                            r_stall <= 1'b0;
                        end else begin
                            r_state <= S_WAIT;
                            r_ctr   <= CTR_INIT;
                            r_stall <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!i_wb_cyc) begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                    end else if (r_ctr == 3'd0) begin
                        r_state <= S_ACK;
                        r_stall <= 1'b0;
                    end else begin
                        r_ctr <= r_ctr - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    // Register bank: commit writes and capture read data on the accept edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 32'h0;
            end
            r_rdata    <= 32'h0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_accept) begin
                if (i_wb_we) begin
                    if (w_in_range && !w_is_ro) begin
                        for (int b = 0; b < 4; b++) begin
                            if (i_wb_sel[b]) begin
                                r_regs[w_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
                            end
                        end
                        r_wr_pulse[w_idx] <= 1'b1;
                    end
                end else begin
                    if (!w_in_range) begin
                        r_rdata <= 32'h0;
                    end else if (w_is_ro) begin
                        r_rdata <= w_ro_word;
                    end else begin
                        r_rdata <= r_regs[w_idx];
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_out
            assign o_regs[32*g +: 32] = RO_MASK[g] ? 32'h0 : r_regs[g];
        end
    endgenerate

endmodule
